mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arb_pkg.sv | 13 +
 rtl/mul_arbiter_if.sv | 36 +++
 rtl/paramul.sv | 22 ++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/mul_arbiter.sv | 122 ++++++++++++
 tb/tb_mul_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mul_arb_pkg.sv
// Shared constants for the multiply arbiter.
//   OPW      operand width of each requester's a/b
//   PRODW    full product width
//   SIGN_W   width of the captured signed/unsigned flag
//   NREQ_DEF default number of requesters sharing the multiplier
package mul_arb_pkg;

    localparam int OPW      = 32;
    localparam int PRODW    = 64;
    localparam int SIGN_W   = 1;
    localparam int NREQ_DEF = 4;

endpackage

// File: rtl/mul_arbiter_if.sv
// Request/response bundle between the requesters/consumer and mul_arbiter.
//   req_valid/req_ready/req_a/req_b/req_sign : per-requester request channel,
//                                              requester i at [OPW*i +: OPW]
//   rsp_valid/rsp_ready/rsp_id/rsp_product   : single response channel
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. A requester holds valid and its payload stable until accepted;
// ready never depends on a later beat, and the response payload holds stable
// while rsp_valid && !rsp_ready.
interface mul_arbiter_if
    import mul_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OPW-1:0]  req_a;
    logic [NREQ*OPW-1:0]  req_b;
    logic [NREQ-1:0]      req_sign;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [PRODW-1:0]     rsp_product;

    // Requester / consumer side.
    modport master (
        output req_valid, req_a, req_b, req_sign, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, req_sign, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product
    );
endinterface

// File: rtl/paramul.sv
// Combinational W x W multiplier with a runtime signed/unsigned select.
//   a, b    : operands
//   sign    : 1 = two's-complement operands, 0 = unsigned
//   product : exact 2W-bit product
module paramul #(
    parameter int W = 32
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           sign,
    output logic [2*W-1:0] product
);
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;

    // Extending each operand to 2W bits (sign- or zero-) makes the low 2W bits
    // of a plain unsigned multiply equal the exact product in either mode.
    assign a_ext   = {{W{sign & a[W-1]}}, a};
    assign b_ext   = {{W{sign & b[W-1]}}, b};
    assign product = a_ext * b_ext;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   en         : grant permitted this cycle
//   grant      : one-hot grant (all zero when en is low or nothing requests)
//   grant_id   : index of the granted requester
//   ptr        : current highest-priority index (observable for debug)
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic [IDW-1:0]  ptr
);
    logic hit;

    // First pass searches ptr..NREQ-1, second pass wraps to 0..; the first
    // set request found wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        hit      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!hit && en && req[i] && (IDW'(i) >= ptr)) begin
                grant[i] = 1'b1;
                grant_id = IDW'(i);
                hit      = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!hit && en && req[i]) begin
                grant[i] = 1'b1;
                grant_id = IDW'(i);
                hit      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (hit) begin
            ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one paramul between NREQ requesters through a two-stage pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response bundle (slave side)
//   busy       : any pipeline stage holds an entry
//   ptr        : round-robin priority pointer (debug view)
// S1 holds the granted operands and feeds the multiplier; S2 holds the
// product and drives the response channel.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_arbiter_if.slave   bus,
    output logic           busy,
    output logic [IDW-1:0] ptr
);
    logic              s1_valid;
    logic [OPW-1:0]    s1_a;
    logic [OPW-1:0]    s1_b;
    logic [SIGN_W-1:0] s1_sign;
    logic [IDW-1:0]    s1_id;

    logic              s2_valid;
    logic [PRODW-1:0]  s2_product;
    logic [IDW-1:0]    s2_id;

    logic              adv2;
    logic              issue;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_id;
    logic [OPW-1:0]    sel_a;
    logic [OPW-1:0]    sel_b;
    logic [SIGN_W-1:0] sel_sign;
    logic [PRODW-1:0]  product;

    // S2 can take a new entry if it is empty or its entry leaves this cycle;
    // S1 can take one if it is empty or moves into S2. Reset also blocks
    // grants so req_ready is low while rst_n is asserted.
    assign adv2  = !s2_valid || bus.rsp_ready;
    assign issue = (!s1_valid || adv2) && rst_n;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus.req_valid),
        .en       (issue),
        .grant    (grant),
        .grant_id (grant_id),
        .ptr      (ptr)
    );

    assign bus.req_ready = grant;

    // One-hot grant makes an OR-mux sufficient.
    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_sign = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a    = bus.req_a[i*OPW +: OPW];
                sel_b    = bus.req_b[i*OPW +: OPW];
                sel_sign = bus.req_sign[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sign  <= '0;
            s1_id    <= '0;
        end else if (issue) begin
            s1_valid <= |grant;
            if (|grant) begin
                s1_a    <= sel_a;
                s1_b    <= sel_b;
                s1_sign <= sel_sign;
                s1_id   <= grant_id;
            end
        end
    end

    paramul #(
        .W (OPW)
    ) u_paramul (
        .a       (s1_a),
        .b       (s1_b),
        .sign    (s1_sign[0]),
        .product (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_product <= '0;
            s2_id      <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            // Payload only changes on a real entry so an idle S2 keeps its
            // last value instead of tracking stale S1 contents.
            if (s1_valid) begin
                s2_product <= product;
                s2_id      <= s1_id;
            end
        end
    end

    assign bus.rsp_valid   = s2_valid;
    assign bus.rsp_id      = s2_id;
    assign bus.rsp_product = s2_product;
    assign busy            = s1_valid || s2_valid;

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int NRAND  = 10000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           busy;
    logic [IDW-1:0] ptr;

    mul_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    mul_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .ptr   (ptr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: {id, product} in acceptance order.
    logic [IDW+63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product from integer arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'(int'(a));
            sb = longint'(int'(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sign  = '0;
        bus.rsp_ready = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic s);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
        bus.req_sign[i]       = s;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Single request, bounded waits for accept and response.
    task automatic send_and_get(input string tag, input int i, input logic [31:0] a,
                                input logic [31:0] b, input logic s,
                                input logic [63:0] exp_prod);
        int w;
        set_op(i, a, b, s);
        bus.req_valid[i] = 1'b1;
        bus.rsp_ready    = 1'b1;
        #1;
        w = 0;
        while (!bus.req_ready[i] && w < 20) begin
            tick();
            w++;
        end
        chk({tag, "_accept"}, 64'(bus.req_ready[i]), 64'd1);
        tick();
        bus.req_valid[i] = 1'b0;
        #1;
        w = 0;
        while (!bus.rsp_valid && w < 20) begin
            tick();
            w++;
        end
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
        chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'(i));
        chk({tag, "_product"}, bus.rsp_product, exp_prod);
        tick();
    endtask

    // ---------------- stimulus ----------------
    logic [NREQ-1:0] pending;
    logic [31:0]     op_a [NREQ];
    logic [31:0]     op_b [NREQ];
    logic            op_s [NREQ];
    int              n_gen, n_acc, n_rsp, cyc;
    logic            prev_stall;
    logic [IDW-1:0]  prev_id;
    logic [63:0]     prev_prod;

    initial begin
        // ---- reset values (inputs requesting to prove req_ready stays low)
        rst_n = 1'b0;
        drive_idle();
        bus.req_valid = 4'hF;
        #12;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_product", bus.rsp_product, 64'd0);
        chk("rst_ptr", 64'(ptr), 64'd0);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---- single unsigned request, exact 2-cycle latency
        set_op(0, 32'd3, 32'd5, 1'b0);
        bus.req_valid = 4'b0001;
        #1;
        chk("single_ready", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = '0;
        #1;
        chk("single_lat1_valid", 64'(bus.rsp_valid), 64'd0);
        chk("single_lat1_busy", 64'(busy), 64'd1);
        tick();
        chk("single_lat2_valid", 64'(bus.rsp_valid), 64'd1);
        chk("single_id", 64'(bus.rsp_id), 64'd0);
        chk("single_product", bus.rsp_product, 64'd15);
        tick();
        chk("single_done_valid", 64'(bus.rsp_valid), 64'd0);
        chk("single_done_busy", 64'(busy), 64'd0);

        // ---- sign handling
        send_and_get("signed", 2, 32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        send_and_get("unsigned", 2, 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE);
        send_and_get("minneg", 1, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);

        // ---- contention: full rate round robin
        apply_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'd10, 1'b0);
        bus.req_valid = 4'hF;
        #1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("rr_grant_c%0d", c), 64'(bus.req_ready), 64'(1 << (c % 4)));
            if (c >= 2) begin
                chk($sformatf("rr_rsp_valid_c%0d", c), 64'(bus.rsp_valid), 64'd1);
                chk($sformatf("rr_rsp_id_c%0d", c), 64'(bus.rsp_id), 64'((c - 2) % 4));
                chk($sformatf("rr_rsp_prod_c%0d", c), bus.rsp_product,
                    64'(((c - 2) % 4 + 1) * 10));
            end
            tick();
        end
        bus.req_valid = '0;
        #1;
        chk("rr_tail_id2", 64'(bus.rsp_id), 64'd2);
        chk("rr_tail_prod2", bus.rsp_product, 64'd30);
        tick();
        chk("rr_tail_id3", 64'(bus.rsp_id), 64'd3);
        chk("rr_tail_prod3", bus.rsp_product, 64'd40);
        tick();
        chk("rr_drained_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rr_drained_busy", 64'(busy), 64'd0);

        // ---- backpressure: fill, stall 5 cycles, release
        apply_reset();
        bus.rsp_ready = 1'b0;
        set_op(0, 32'd100, 32'd3, 1'b0);
        set_op(1, 32'd200, 32'd3, 1'b0);
        bus.req_valid = 4'b0011;
        #1;
        chk("bp_grant0", 64'(bus.req_ready), 64'h1);
        tick();
        chk("bp_grant1", 64'(bus.req_ready), 64'h2);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_stall%0d_valid", k), 64'(bus.rsp_valid), 64'd1);
            chk($sformatf("bp_stall%0d_id", k), 64'(bus.rsp_id), 64'd0);
            chk($sformatf("bp_stall%0d_prod", k), bus.rsp_product, 64'd300);
            chk($sformatf("bp_stall%0d_ready", k), 64'(bus.req_ready), 64'd0);
            chk($sformatf("bp_stall%0d_busy", k), 64'(busy), 64'd1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        #1;
        chk("bp_out0_valid", 64'(bus.rsp_valid), 64'd1);
        chk("bp_out0_id", 64'(bus.rsp_id), 64'd0);
        chk("bp_out0_prod", bus.rsp_product, 64'd300);
        tick();
        chk("bp_out1_valid", 64'(bus.rsp_valid), 64'd1);
        chk("bp_out1_id", 64'(bus.rsp_id), 64'd1);
        chk("bp_out1_prod", bus.rsp_product, 64'd600);
        tick();
        chk("bp_no_dup", 64'(bus.rsp_valid), 64'd0);
        tick();
        chk("bp_idle_busy", 64'(busy), 64'd0);

        // ---- reset while both stages hold entries
        apply_reset();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0011;
        tick();
        tick();
        chk("mrst_full_busy", 64'(busy), 64'd1);
        chk("mrst_full_valid", 64'(bus.rsp_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("mrst_prod", bus.rsp_product, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_op(1, 32'd7, 32'd7, 1'b0);
        set_op(3, 32'hFFFF_FFF5, 32'hFFFF_FFFD, 1'b1);
        bus.req_valid = 4'b1010;
        bus.rsp_ready = 1'b1;
        #1;
        chk("mrst_first_grant", 64'(bus.req_ready), 64'h2);
        tick();
        chk("mrst_second_grant", 64'(bus.req_ready), 64'h8);
        chk("mrst_no_stale", 64'(bus.rsp_valid), 64'd0);
        tick();
        bus.req_valid = '0;
        #1;
        chk("mrst_rsp1_id", 64'(bus.rsp_id), 64'd1);
        chk("mrst_rsp1_prod", bus.rsp_product, 64'd49);
        tick();
        chk("mrst_rsp3_id", 64'(bus.rsp_id), 64'd3);
        chk("mrst_rsp3_prod", bus.rsp_product, 64'd33);
        tick();
        chk("mrst_end_valid", 64'(bus.rsp_valid), 64'd0);

        // ---- random regression against the scoreboard
        apply_reset();
        drive_idle();
        pending    = '0;
        n_gen      = 0;
        n_acc      = 0;
        n_rsp      = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_id    = '0;
        prev_prod  = '0;
        while ((n_acc < NRAND || exp_q.size() != 0) && cyc < 90000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && n_gen < NRAND && $urandom_range(0, 3) != 0) begin
                    op_a[i]    = rand_op();
                    op_b[i]    = rand_op();
                    op_s[i]    = 1'($urandom_range(0, 1));
                    set_op(i, op_a[i], op_b[i], op_s[i]);
                    pending[i] = 1'b1;
                    n_gen++;
                end
            end
            bus.req_valid = pending;
            bus.rsp_ready = (n_gen >= NRAND) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_onehot", 64'((bus.req_ready & (bus.req_ready - 4'd1)) == 4'd0), 64'd1);
            chk("rnd_ready_subset", 64'(bus.req_ready & ~bus.req_valid), 64'd0);
            if (prev_stall) begin
                chk("rnd_stall_valid", 64'(bus.rsp_valid), 64'd1);
                chk("rnd_stall_id", 64'(bus.rsp_id), 64'(prev_id));
                chk("rnd_stall_prod", bus.rsp_product, prev_prod);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    exp_q.push_back({IDW'(i), ref_mul(op_a[i], op_b[i], op_s[i])});
                    pending[i] = 1'b0;
                    n_acc++;
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                int  idx;
                logic found;
                idx   = 0;
                found = 1'b0;
                for (int k = 0; k < exp_q.size(); k++) begin
                    if (!found && exp_q[k][IDW+63:64] == bus.rsp_id) begin
                        idx   = k;
                        found = 1'b1;
                    end
                end
                chk("rnd_rsp_expected", 64'(found), 64'd1);
                if (found) begin
                    chk($sformatf("rnd_prod_id%0d", bus.rsp_id), bus.rsp_product,
                        exp_q[idx][63:0]);
                    exp_q.delete(idx);
                end
                n_rsp++;
            end
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            prev_id    = bus.rsp_id;
            prev_prod  = bus.rsp_product;
            tick();
            cyc++;
        end
        bus.req_valid = '0;
        #1;
        chk("rnd_all_accepted", 64'(n_acc), 64'(NRAND));
        chk("rnd_all_delivered", 64'(n_rsp), 64'(NRAND));
        chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("rnd_final_busy", 64'(busy), 64'd0);
        chk("rnd_final_valid", 64'(bus.rsp_valid), 64'd0);

        // ---- final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
